// File: rtl/life_engine_serial.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : life_engine_serial                                              |
// | Purpose  : Game of Life engine; one cell per clock into a shadow board,    |
// |            atomic commit, frame pacing, step, reload and still-life flag.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module life_engine_serial #(
  parameter int W_BITS         = 3,
  parameter int H_BITS         = 3,
  parameter int FRAMES_PER_GEN = 60,
  parameter logic [(1<<(W_BITS+H_BITS))-1:0] SEED = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              run,
  input  logic              step,
  input  logic              load,
  input  logic              wrap,
  input  logic [W_BITS-1:0] rd_x,
  input  logic [H_BITS-1:0] rd_y,
  output logic              rd_cell,
  output logic              busy,
  output logic              gen_done,
  output logic              stable,
  output logic [15:0]       gen_count
);

  localparam int W  = 1 << W_BITS;
  localparam int H  = 1 << H_BITS;
  localparam int IW = W_BITS + H_BITS;
  localparam int N  = 1 << IW;
  localparam int FW = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_COMMIT  = 2'd2
  } state_t;

  state_t            r_state;
  logic [N-1:0]      r_board;
  logic [N-1:0]      r_nxt;
  logic [IW-1:0]     r_idx;
  logic [FW-1:0]     r_frame_cnt;
  logic              r_pending;
  logic              r_wrap_q;
  logic [15:0]       r_gen_count;
  logic              r_stable;
  logic              r_busy;
  logic              r_gen_done;

  logic [W_BITS-1:0] w_x;
  logic [H_BITS-1:0] w_y;
  logic [3:0]        w_cnt;
  logic              w_new;
  logic              w_ovf;

  // Truncating the coordinates to the board width gives the toroidal index for free.
  function automatic logic f_alive(input logic [N-1:0] b, input int x, input int y,
                                   input logic wr);
    logic          inr;
    logic [IW-1:0] li;
    inr = wr || (x >= 0 && x < W && y >= 0 && y < H);
    li  = {H_BITS'(y), W_BITS'(x)};
    return inr & b[li];
  endfunction

  assign w_x = r_idx[W_BITS-1:0];
  assign w_y = r_idx[IW-1:W_BITS];

  always_comb begin
    w_cnt = '0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        if (dx != 0 || dy != 0) begin
          w_cnt = w_cnt + 4'(f_alive(r_board, int'(w_x) + dx, int'(w_y) + dy, r_wrap_q));
        end
      end
    end
  end

  assign w_new = (w_cnt == 4'd3) | (r_board[r_idx] & (w_cnt == 4'd2));
  assign w_ovf = run & tick & (r_frame_cnt == FW'(FRAMES_PER_GEN - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_board     <= SEED;
      r_nxt       <= '0;
      r_idx       <= '0;
      r_frame_cnt <= '0;
      r_pending   <= 1'b0;
      r_wrap_q    <= 1'b0;
      r_gen_count <= '0;
      r_stable    <= 1'b0;
      r_busy      <= 1'b0;
      r_gen_done  <= 1'b0;
    end else if (load) begin
      r_state     <= S_IDLE;
      r_board     <= SEED;
      r_frame_cnt <= '0;
      r_pending   <= 1'b0;
      r_gen_count <= '0;
      r_stable    <= 1'b0;
      r_busy      <= 1'b0;
      r_gen_done  <= 1'b0;
    end else begin
      r_gen_done <= 1'b0;
      if (!run) begin
        r_frame_cnt <= '0;
      end else if (tick) begin
        r_frame_cnt <= w_ovf ? '0 : r_frame_cnt + FW'(1);
      end
      if (w_ovf && !r_pending) begin
        r_pending <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (r_pending || (step && !run)) begin
            r_pending <= 1'b0;
            r_wrap_q  <= wrap;
            r_idx     <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          r_nxt[r_idx] <= w_new;
          if (r_idx == IW'(N - 1)) begin
            r_state <= S_COMMIT;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        S_COMMIT: begin
          r_board     <= r_nxt;
          r_stable    <= (r_nxt == r_board);
          r_gen_count <= r_gen_count + 16'd1;
          r_gen_done  <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_cell   = r_board[{rd_y, rd_x}];
  assign busy      = r_busy;
  assign gen_done  = r_gen_done;
  assign stable    = r_stable;
  assign gen_count = r_gen_count;

endmodule
`default_nettype wire

// File: tb/tb_life_engine_serial.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_life_engine_serial                                           |
// | Purpose  : Four 8x8 engines with different seeds/pacing against a          |
// |            generation-level reference model; directed and random stimulus. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_life_engine_serial;

  localparam logic [63:0] S_BLINK  = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] S_VERT   = 64'h0000_0008_0808_0000;
  localparam logic [63:0] S_EDGE   = 64'h0000_0000_0000_0007;
  localparam logic [63:0] E_EDGE0  = 64'h0000_0000_0000_0202;
  localparam logic [63:0] E_EDGE1  = 64'h0200_0000_0000_0202;
  localparam logic [63:0] S_GLIDER = 64'h0000_0000_0007_0402;
  localparam logic [63:0] S_BLOCK  = 64'h0000_0018_1800_0000;

  localparam logic [63:0] SEEDS [4] = '{S_BLINK, S_EDGE, S_GLIDER, S_BLOCK};
  localparam int          FPGS  [4] = '{60, 3, 1, 2};

  logic        clk = 1'b0;
  logic        rst_n, tick, run, step, load, wrap;
  logic [2:0]  rd_x, rd_y;
  logic [3:0]  d_cell, d_busy, d_gd, d_st;
  logic [15:0] d_gc [4];

  int n_vec = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #200 clk = ~clk;

  life_engine_serial #(.W_BITS(3), .H_BITS(3), .FRAMES_PER_GEN(60), .SEED(S_BLINK)) u0 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .run(run), .step(step), .load(load), .wrap(wrap),
    .rd_x(rd_x), .rd_y(rd_y), .rd_cell(d_cell[0]), .busy(d_busy[0]), .gen_done(d_gd[0]),
    .stable(d_st[0]), .gen_count(d_gc[0]));
  life_engine_serial #(.W_BITS(3), .H_BITS(3), .FRAMES_PER_GEN(3), .SEED(S_EDGE)) u1 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .run(run), .step(step), .load(load), .wrap(wrap),
    .rd_x(rd_x), .rd_y(rd_y), .rd_cell(d_cell[1]), .busy(d_busy[1]), .gen_done(d_gd[1]),
    .stable(d_st[1]), .gen_count(d_gc[1]));
  life_engine_serial #(.W_BITS(3), .H_BITS(3), .FRAMES_PER_GEN(1), .SEED(S_GLIDER)) u2 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .run(run), .step(step), .load(load), .wrap(wrap),
    .rd_x(rd_x), .rd_y(rd_y), .rd_cell(d_cell[2]), .busy(d_busy[2]), .gen_done(d_gd[2]),
    .stable(d_st[2]), .gen_count(d_gc[2]));
  life_engine_serial #(.W_BITS(3), .H_BITS(3), .FRAMES_PER_GEN(2), .SEED(S_BLOCK)) u3 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .run(run), .step(step), .load(load), .wrap(wrap),
    .rd_x(rd_x), .rd_y(rd_y), .rd_cell(d_cell[3]), .busy(d_busy[3]), .gen_done(d_gd[3]),
    .stable(d_st[3]), .gen_count(d_gc[3]));

  // Reference: whole next generation computed from the rules, released after N+1 cycles.
  function automatic logic [63:0] life(input logic [63:0] b, input bit wr);
    logic [63:0] r;
    r = '0;
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        int c;
        logic [5:0] bi;
        c = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            int nx, ny;
            nx = x + dx;
            ny = y + dy;
            if (wr) begin
              nx = (nx + 8) % 8;
              ny = (ny + 8) % 8;
            end
            if ((dx != 0 || dy != 0) && nx >= 0 && nx < 8 && ny >= 0 && ny < 8) begin
              bi = 6'(ny * 8 + nx);
              if (b[bi]) c++;
            end
          end
        end
        bi = 6'(y * 8 + x);
        r[bi] = (c == 3) || (b[bi] && c == 2);
      end
    end
    return r;
  endfunction

  logic [63:0] mb [4];
  logic [63:0] mn [4];
  int          mleft [4];
  int          mfc [4];
  bit          mpend [4];
  bit          mst [4];
  bit          mgd [4];
  logic [15:0] mgc [4];

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (!rst_n || load) begin
        mb[k] = SEEDS[k]; mleft[k] = 0; mfc[k] = 0; mpend[k] = 0;
        mst[k] = 0; mgd[k] = 0; mgc[k] = '0;
      end else begin
        bit ovf;
        mgd[k] = 0;
        ovf = run && tick && (mfc[k] == FPGS[k] - 1);
        if (!run) mfc[k] = 0;
        else if (tick) mfc[k] = ovf ? 0 : mfc[k] + 1;
        if (mleft[k] == 0) begin
          if (mpend[k] || (step && !run)) begin
            mpend[k] = 0;
            mn[k] = life(mb[k], wrap);
            mleft[k] = 65;
          end else if (ovf) begin
            mpend[k] = 1;
          end
        end else begin
          if (ovf) mpend[k] = 1;
          mleft[k]--;
          if (mleft[k] == 0) begin
            mst[k] = (mn[k] == mb[k]);
            mb[k] = mn[k];
            mgc[k] = mgc[k] + 16'd1;
            mgd[k] = 1;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] t=%0t got %h want %h", nm, k, $time, act, exp);
    end
  endtask

  logic [63:0] dboard [4];
  int          gd_cnt [4] = '{0, 0, 0, 0};

  always @(negedge clk) begin
    for (int i = 0; i < 64; i++) begin
      {rd_y, rd_x} = 6'(i);
      #1;
      for (int k = 0; k < 4; k++) dboard[k][i] = d_cell[k];
    end
    for (int k = 0; k < 4; k++) begin
      if (d_gd[k]) gd_cnt[k]++;
      if (chk_en) begin
        chk("board",    k, dboard[k],       mb[k]);
        chk("busy",     k, 64'(d_busy[k]),  64'(mleft[k] != 0));
        chk("gen_done", k, 64'(d_gd[k]),    64'(mgd[k]));
        chk("stable",   k, 64'(d_st[k]),    64'(mst[k]));
        chk("gen_cnt",  k, 64'(d_gc[k]),    64'(mgc[k]));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    #100;
  endtask

  task automatic pulse_step();
    step = 1'b1; cyc(1); step = 1'b0;
  endtask

  task automatic pulse_load();
    load = 1'b1; cyc(1); load = 1'b0;
  endtask

  task automatic pulse_tick();
    tick = 1'b1; cyc(1); tick = 1'b0;
  endtask

  initial begin
    int base;
    rst_n = 1'b0; tick = 1'b0; run = 1'b0; step = 1'b0; load = 1'b0; wrap = 1'b0;
    rd_x = '0; rd_y = '0;
    cyc(3);
    chk_en = 1'b1;
    sample();
    chk("rst_board", 0, dboard[0], S_BLINK);
    chk("rst_gc",    0, 64'(d_gc[0]), 64'd0);
    rst_n = 1'b1;
    cyc(1);

    // Model pinned to hand-derived generations
    chk("model_blink", 0, life(S_BLINK, 1'b0), S_VERT);
    chk("model_edge0", 1, life(S_EDGE, 1'b0), E_EDGE0);
    chk("model_edge1", 1, life(S_EDGE, 1'b1), E_EDGE1);
    chk("model_block", 3, life(S_BLOCK, 1'b1), S_BLOCK);

    // Blinker / edge / block single step, wrap=0
    pulse_step();
    cyc(63); sample();
    chk("lat_busy64", 0, 64'(d_busy[0]), 64'd1);
    cyc(1); sample();
    chk("lat_busy65", 0, 64'(d_busy[0]), 64'd1);
    chk("lat_old",    0, dboard[0], S_BLINK);
    cyc(1); sample();
    chk("blink_board", 0, dboard[0], S_VERT);
    chk("blink_gd",    0, 64'(d_gd[0]), 64'd1);
    chk("blink_gc",    0, 64'(d_gc[0]), 64'd1);
    chk("blink_st",    0, 64'(d_st[0]), 64'd0);
    chk("edge0_board", 1, dboard[1], E_EDGE0);
    chk("block_board", 3, dboard[3], S_BLOCK);
    chk("block_st",    3, 64'(d_st[3]), 64'd1);
    cyc(1); sample();
    chk("gd_pulse", 0, 64'(d_gd[0]), 64'd0);
    pulse_step();
    cyc(70); sample();
    chk("blink2_board", 0, dboard[0], S_BLINK);

    // Edge mode with wrap
    pulse_load();
    wrap = 1'b1;
    pulse_step();
    cyc(70); sample();
    chk("edge1_board", 1, dboard[1], E_EDGE1);

    // Glider on the torus, one generation per tick
    pulse_load();
    run = 1'b1;
    base = gd_cnt[2];
    for (int t = 0; t < 32; t++) begin
      pulse_tick();
      cyc(70);
    end
    sample();
    chk("glider_gd",    2, 64'(gd_cnt[2] - base), 64'd32);
    chk("glider_board", 2, dboard[2], S_GLIDER);
    chk("glider_gc",    2, 64'(d_gc[2]), 64'd32);
    run = 1'b0;
    cyc(2);

    // Frame pacing on the 60-frame engine
    pulse_load();
    run = 1'b1;
    for (int t = 0; t < 59; t++) begin
      pulse_tick(); cyc(1);
    end
    sample();
    chk("pace59", 0, 64'(d_busy[0]), 64'd0);
    pulse_tick(); cyc(1); sample();
    chk("pace60", 0, 64'(d_busy[0]), 64'd1);
    cyc(70);
    for (int t = 0; t < 30; t++) begin
      pulse_tick(); cyc(1);
    end
    run = 1'b0; cyc(2); run = 1'b1;
    for (int t = 0; t < 59; t++) begin
      step = 1'b1; tick = 1'b1; cyc(1); step = 1'b0; tick = 1'b0; cyc(1);
    end
    sample();
    chk("pace_restart59", 0, 64'(d_busy[0]), 64'd0);
    pulse_tick(); cyc(1); sample();
    chk("pace_restart60", 0, 64'(d_busy[0]), 64'd1);
    run = 1'b0;
    cyc(70);

    // Abort with load mid-compute
    pulse_load();
    wrap = 1'b0;
    pulse_step(); cyc(70);
    base = gd_cnt[0];
    pulse_step();
    cyc(30);
    pulse_load();
    sample();
    chk("abort_busy",  0, 64'(d_busy[0]), 64'd0);
    chk("abort_board", 0, dboard[0], S_BLINK);
    chk("abort_gc",    0, 64'(d_gc[0]), 64'd0);
    cyc(70);
    chk("abort_nogd",  0, 64'(gd_cnt[0] - base), 64'd0);

    // Reset during COMMIT
    pulse_step();
    cyc(64);
    rst_n = 1'b0; cyc(1); rst_n = 1'b1;
    sample();
    chk("rstc_board", 0, dboard[0], S_BLINK);
    chk("rstc_gc",    0, 64'(d_gc[0]), 64'd0);
    chk("rstc_busy",  0, 64'(d_busy[0]), 64'd0);
    chk("rstc_gd",    0, 64'(d_gd[0]), 64'd0);
    chk("rstc_st",    0, 64'(d_st[0]), 64'd0);

    // Random traffic checked every cycle against the model
    for (int c = 0; c < 3000; c++) begin
      tick  = ($urandom_range(0, 3) == 0);
      step  = ($urandom_range(0, 15) == 0);
      load  = ($urandom_range(0, 299) == 0);
      rst_n = ($urandom_range(0, 999) != 0);
      wrap  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 199) == 0) run = ~run;
      cyc(1);
    end
    tick = 1'b0; step = 1'b0; load = 1'b0; rst_n = 1'b1; run = 1'b0;
    cyc(80);
    sample();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
